// File: rtl/detect_event_counter.sv
// detect_event_counter
//   Counts detection events from an upstream sequence-detector FSM in a
//   4-digit BCD counter that saturates at SAT_VALUE, keeps a sticky
//   overflow flag, and drives a time-multiplexed 4-digit active-low
//   seven-segment display (Basys3 style).
//
// Optional build macro: DETECT_EDGE_ONLY_EN
//   undefined : every clock cycle with z high counts once (inc = z_q)
//   defined   : only the rising edge of z counts (inc = z_q & ~z_qq)
//
// Ports
//   clk  in   system clock, rising edge
//   rst  in   asynchronous reset, active low
//   z    in   detection output of the upstream FSM (may be combinational)
//   clr  in   synchronous count clear, active high, wins over an event
//   bcd  out  registered count {d3,d2,d1,d0}
//   ovf  out  sticky: an event arrived while the count was at SAT_VALUE
//   an   out  digit enables, active-low one-hot
//   seg  out  segments {g,f,e,d,c,b,a}, active low
//   dp   out  decimal point, active low; lit on digit 3 when ovf is set
//
// There is no handshake: bcd/ovf are plain registered levels, and
// an/seg/dp are combinational decodes of registers only, so they are
// glitch-free.

module detect_event_counter #(
    parameter int REFRESH_BITS = 17,
    parameter int SAT_VALUE    = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        z,
    input  logic        clr,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [15:0] SAT_BCD = {4'((SAT_VALUE / 1000) % 10),
                                       4'((SAT_VALUE / 100) % 10),
                                       4'((SAT_VALUE / 10) % 10),
                                       4'(SAT_VALUE % 10)};

    logic                    z_q;
    logic                    inc;
    logic [15:0]             count;
    logic [15:0]             count_inc;
    logic                    carry;
    logic                    ovf_q;
    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic                    blank;

    // Input register: z may be a combinational Mealy output, so it is
    // sampled once before it touches any counter logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_q <= 1'b0;
        end else begin
            z_q <= z;
        end
    end

`ifdef DETECT_EDGE_ONLY_EN
    logic z_qq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_qq <= 1'b0;
        end else begin
            z_qq <= z_q;
        end
    end

    assign inc = z_q & ~z_qq;
`else
    assign inc = z_q;
`endif

    // BCD increment: ripple the carry through the digits so 0999 becomes
    // 1000 within one cycle.
    always_comb begin
        count_inc = count;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count[i*4 +: 4] == 4'd9) begin
                    count_inc[i*4 +: 4] = 4'd0;
                    carry               = 1'b1;
                end else begin
                    count_inc[i*4 +: 4] = count[i*4 +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 16'h0000;
            ovf_q <= 1'b0;
        end else if (clr) begin
            count <= 16'h0000;
            ovf_q <= 1'b0;
        end else if (inc && (count == SAT_BCD)) begin
            ovf_q <= 1'b1;
        end else if (inc) begin
            count <= count_inc;
        end
    end

    assign bcd = count;
    assign ovf = ovf_q;

    // Free-running refresh counter; its top two bits pick the digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh <= '0;
        end else begin
            refresh <= refresh + REFRESH_BITS'(1);
        end
    end

    assign sel = refresh[REFRESH_BITS-1 -: 2];

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Digit select with leading-zero blanking: a digit is dark when it
    // and every digit above it are zero. Digit 0 is always shown.
    always_comb begin
        an    = 4'b1110;
        digit = count[3:0];
        blank = 1'b0;
        case (sel)
            2'd0: begin
                an    = 4'b1110;
                digit = count[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                an    = 4'b1101;
                digit = count[7:4];
                blank = (count[15:4] == 12'h000);
            end
            2'd2: begin
                an    = 4'b1011;
                digit = count[11:8];
                blank = (count[15:8] == 8'h00);
            end
            default: begin
                an    = 4'b0111;
                digit = count[15:12];
                blank = (count[15:12] == 4'h0);
            end
        endcase
    end

    assign seg = blank ? 7'b1111111 : seg_decode(digit);
    assign dp  = ~((sel == 2'd3) & ovf_q);

endmodule

// File: tb/tb_detect_event_counter.sv
// Testbench for detect_event_counter.
//   Driver tasks issue z/clr per clock and advance a cycle model of the
//   counter; every count change the model predicts is pushed into exp_q.
//   A monitor process pops exp_q whenever bcd changes and compares.
//   Directed spot checks use hand-computed constants.
//   Works in both builds (DETECT_EDGE_ONLY_EN defined or not).

module tb_detect_event_counter;

    localparam int RB  = 4;
    localparam int SAT = 9999;

`ifdef DETECT_EDGE_ONLY_EN
    localparam logic [15:0] EXP_RUN11 = 16'h0001;
    localparam logic [15:0] EXP_RUN12 = 16'h0001;
    localparam logic [15:0] EXP_PAT   = 16'h0003;
`else
    localparam logic [15:0] EXP_RUN11 = 16'h0011;
    localparam logic [15:0] EXP_RUN12 = 16'h0012;
    localparam logic [15:0] EXP_PAT   = 16'h0006;
`endif

    // clock / reset
    logic        clk;
    logic        rst;
    logic        z;
    logic        clr;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    detect_event_counter #(
        .REFRESH_BITS(RB),
        .SAT_VALUE   (SAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .z  (z),
        .clr(clr),
        .bcd(bcd),
        .ovf(ovf),
        .an (an),
        .seg(seg),
        .dp (dp)
    );

    // scoreboard state
    logic [15:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    // model state
    int   m_count = 0;
    logic m_ovf   = 1'b0;
    logic m_zq    = 1'b0;
    logic m_zqq   = 1'b0;
    int   cyc     = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                 7'b0110000, 7'b0011001, 7'b0010010,
                                 7'b0000010, 7'b1111000, 7'b0000000,
                                 7'b0010000};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_ovf   = 1'b0;
        m_zq    = 1'b0;
        m_zqq   = 1'b0;
        cyc     = 0;
        exp_q.delete();
    endtask

    // One rising edge of the model.
    task automatic model_edge(input logic zv, input logic cv);
        logic inc_m;
`ifdef DETECT_EDGE_ONLY_EN
        inc_m = m_zq & ~m_zqq;
`else
        inc_m = m_zq;
`endif
        if (cv) begin
            if (m_count != 0) exp_q.push_back(16'h0000);
            m_count = 0;
            m_ovf   = 1'b0;
        end else if (inc_m) begin
            if (m_count == SAT) begin
                m_ovf = 1'b1;
            end else begin
                m_count++;
                exp_q.push_back(to_bcd(m_count));
            end
        end
        m_zqq = m_zq;
        m_zq  = zv;
        cyc++;
    endtask

    // driver tasks
    task automatic drive_cycle(input logic zv, input logic cv);
        z   = zv;
        clr = cv;
        @(posedge clk);
        model_edge(zv, cv);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b1, 1'b0);
            drive_cycle(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        z   = 1'b0;
        clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Compares an/seg/dp/ovf with the digit the refresh counter selects.
    task automatic check_display();
        int         s;
        int         d;
        int         p;
        logic       blank_e;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        s       = (cyc >> (RB - 2)) & 3;
        p       = 10 ** s;
        d       = (m_count / p) % 10;
        blank_e = (s > 0) && (m_count < p);
        an_e    = ~(4'b0001 << s);
        seg_e   = blank_e ? 7'b1111111 : seg_tab[d];
        check("disp_an", 32'(an), 32'(an_e));
        check("disp_seg", 32'(seg), 32'(seg_e));
        check("disp_dp", 32'(dp), 32'(!((s == 3) && m_ovf)));
        check("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic sweep();
        for (int i = 0; i < (1 << RB); i++) begin
            drive_cycle(1'b0, 1'b0);
            check_display();
        end
    endtask

    // monitor: pops an expectation on every change of bcd
    logic [15:0] last_bcd;
    initial begin
        logic [15:0] e;
        last_bcd = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_bcd = 16'h0000;
            end else if (bcd !== last_bcd) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL bcd_unexpected actual=%04h expected=no change at %0t",
                             bcd, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bcd !== e) begin
                        bad++;
                        $display("FAIL bcd_seq actual=%04h expected=%04h at %0t",
                                 bcd, e, $time);
                    end
                end
                last_bcd = bcd;
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // stimulus
    initial begin
        rst = 1'b0;
        z   = 1'b0;
        clr = 1'b0;
        #1;
        check("rst_bcd", 32'(bcd), 32'h0000);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_an", 32'(an), 32'b1110);
        check("rst_seg", 32'(seg), 32'b1000000);
        check("rst_dp", 32'(dp), 32'h1);
        do_reset();

        // idle after reset
        idle(100);
        check("idle_bcd", 32'(bcd), 32'h0000);
        check_display();
        sweep();

        // run of 12 high cycles
        for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b0);
        check("run_bcd_11", 32'(bcd), 32'(EXP_RUN11));
        drive_cycle(1'b0, 1'b0);
        check("run_bcd_12", 32'(bcd), 32'(EXP_RUN12));
        sweep();

        // pattern 1,1,1,0,1,0,0,1,1
        drive_cycle(1'b0, 1'b1);
        check("clr_bcd", 32'(bcd), 32'h0000);
        begin
            logic [8:0] pat;
            pat = 9'b110010111;
            for (int i = 0; i < 9; i++) drive_cycle(pat[i], 1'b0);
        end
        idle(3);
        check("pattern_bcd", 32'(bcd), 32'(EXP_PAT));

        // asynchronous reset in the middle of a cycle
        drive_cycle(1'b0, 1'b1);
        pulses(57);
        idle(3);
        check("pre_rst_bcd", 32'(bcd), 32'h0057);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_bcd", 32'(bcd), 32'h0000);
        check("async_rst_an", 32'(an), 32'b1110);
        check("async_rst_seg", 32'(seg), 32'b1000000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        pulses(5);
        idle(3);
        check("post_rst_bcd", 32'(bcd), 32'h0005);

        // carry chain
        drive_cycle(1'b0, 1'b1);
        pulses(999);
        idle(3);
        check("carry_0999", 32'(bcd), 32'h0999);
        sweep();
        pulses(1);
        idle(3);
        check("carry_1000", 32'(bcd), 32'h1000);
        sweep();

        // saturation and overflow
        pulses(8999);
        idle(3);
        check("sat_bcd", 32'(bcd), 32'h9999);
        check("sat_ovf_pre", 32'(ovf), 32'h0);
        pulses(3);
        idle(3);
        check("sat_hold", 32'(bcd), 32'h9999);
        check("sat_ovf", 32'(ovf), 32'h1);
        sweep();

        // clr wins over a simultaneous event
        drive_cycle(1'b1, 1'b1);
        check("clr_win_bcd", 32'(bcd), 32'h0000);
        check("clr_win_ovf", 32'(ovf), 32'h0);
        idle(3);
        check("after_clr_bcd", 32'(bcd), 32'h0001);

        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/detect_event_counter.md
Name: detect_event_counter

Overview:
- Downstream consumer of the serial sequence-detector FSMs.
- Takes the detector's `z` output, counts detection events in a 4-digit BCD counter that saturates at 9999, and flags overflow.
- Drives a time-multiplexed 4-digit active-low seven-segment display (Basys3-style) so a lab board shows the running detection count.
- Single clock domain, same clock as the detector feeding it.

Parameters:
- REFRESH_BITS, 17: width of the free-running display refresh counter. Its top 2 bits select the active digit.
- SAT_VALUE, 9999: terminal count in decimal. Must be ≤ 9999. Stored internally as BCD.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous active-low reset (0 = reset asserted)
- z  in  1  detection output from the upstream FSM (may be combinational Mealy output)
- clr  in  1  synchronous count clear, active-high
- bcd  out  16  current count, {d3,d2,d1,d0}, 4 bits per digit
- ovf  out  1  sticky flag: an event arrived while the count was at SAT_VALUE
- an  out  4  digit enables, active-low one-hot
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset (rst=0, asynchronous):
  - z_q=0, count=0000, ovf=0, refresh=0.
  - Hence an=4'b1110, seg=7'b1000000 (digit "0"), dp=1.
- Input sampling: z is registered into z_q every clk, so there is 1 cycle of latency before a count.
- inc:
  - inc = z_q in default build: one count per clock cycle that z was high.
  - See the optional feature for the edge-only build.
- Counter update, evaluated in this priority order:
  1. clr=1: count←0000 and ovf←0. clr wins over a simultaneous inc.
  2. inc and count==SAT_VALUE: count holds and ovf←1.
  3. inc: BCD increment. Each digit wraps 9→0 with carry into the next digit in the same cycle (e.g. 0199→0200, 0999→1000).
  4. Otherwise count holds.
- Digit invariant: no digit ever holds 10–15.
- bcd: registered count, updated on the edge where inc takes effect (2 clk after z rises).
- ovf: sticky. Cleared only by clr or rst.
- Display refresh counter:
  - refresh increments every clk and wraps at 2^REFRESH_BITS.
  - sel = refresh[REFRESH_BITS-1:REFRESH_BITS-2].
- Digit mapping (sel → an, digit shown):
  - 0 → an=1110, d0
  - 1 → an=1101, d1
  - 2 → an=1011, d2
  - 3 → an=0111, d3
- an, seg and dp are combinational decodes of sel and the registered count. They are glitch-free because their sources are all registers.
- Segment decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking:
  - A digit above the most significant nonzero digit shows seg=1111111, with its an still driven.
  - d0 is never blanked.
- dp: dp=0 only when sel==3 and ovf=1; otherwise dp=1.
- Reset mid-count: all state returns to reset values immediately, independent of clk.
- The display restarts at sel=0 when rst deasserts.

Optional Feature:
- Macro: DETECT_EDGE_ONLY_EN.
- Defined:
  - Add a second register z_qq (reset 0).
  - inc = z_q & ~z_qq, so a z held high for N cycles counts exactly once.
  - Use this when z is a level (Moore/terminal-state detector).
- Undefined:
  - inc = z_q, so every high cycle counts.
  - z_qq is not instantiated.

Test Plan:
- Reset then idle: rst=0 for 3 clk, release, z=0 for 100 clk → bcd=0000, ovf=0, an=1110, seg=1000000, dp=1.
- Level counting (macro off): z=1 for 12 consecutive clk → bcd=0012 exactly 2 clk after the last high cycle. With sel=1, seg shows "1"; with sel=2, seg=1111111 (blanked).
- Carry chain: force count to 0999 via 999 events, then one more z pulse → bcd=1000. Digits d1/d2 roll in the same cycle, and no digit ever reads A–F.
- Saturation and overflow: reach 9999, 3 more events → bcd stays 9999, ovf=1, dp=0 only when an=0111. Then clr=1 for one clk together with z=1 → bcd=0000, ovf=0.
- Edge-only (DETECT_EDGE_ONLY_EN defined): z pattern 1,1,1,0,1,0,0,1,1 → bcd=0003. The same pattern with the macro undefined → bcd=0006.
- Async reset mid-operation: count at 0057, assert rst between clock edges → bcd=0000 and an=1110 before the next rising edge. Release rst, then 5 z pulses → bcd=0005.
